// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data-memory access unit.
package mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int WB_SIG_W   = 2;

  localparam logic [WB_SIG_W-1:0] WB_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mau_state_e;

endpackage

// File: rtl/mem_timeout_counter.sv
// Bus timeout counter: counts BUSY cycles and flags the last cycle an ack may
// still arrive before the access is abandoned.
module mem_timeout_counter #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expire = (count_q == LAST);

  // Next count; saturates at LAST so non-power-of-two limits never wrap.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CW{1'b0}};
    end else if (enable && !expire) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller with req/ack memory handshake and bus timeout.
// Define MISALIGN_TRAP_EN to trap accesses whose address is not word aligned.
module mem_access_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = mem_stage_pkg::DATA_W,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [REG_ADDR_W-1:0] reg_dst,
  input  logic [WB_SIG_W-1:0]   write_back_signal,
  output logic                  stall,
  output logic [DATA_W-1:0]     result,
  output logic [DATA_W-1:0]     read_data,
  output logic [REG_ADDR_W-1:0] reg_dst_out,
  output logic [WB_SIG_W-1:0]   write_back_signal_out,
  output logic                  bus_error,
  output logic                  misaligned,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack
);

  mau_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;

  logic access;
  logic trap;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expire;

  assign access = valid && (mem_read || mem_write);

`ifdef MISALIGN_TRAP_EN
  assign trap = (alu_result[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  mem_timeout_counter #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expire (cnt_expire)
  );

  // Next-state, stall and memory-request decisions.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    mis_d       = 1'b0;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (trap) begin
            rdata_d = {DATA_W{1'b0}};
            mis_d   = 1'b1;
            state_d = RESP;
          end else begin
            mem_addr_d  = {alu_result[DATA_W-1:2], 2'b00};
            mem_wdata_d = write_data;
            mem_we_d    = mem_write;
            mem_req_d   = 1'b1;
            cnt_clear   = 1'b1;
            state_d     = BUSY;
          end
        end else begin
          stall = 1'b0;
        end
      end
      BUSY: begin
        stall      = 1'b1;
        cnt_enable = 1'b1;
        // An ack in the expiry cycle still completes the access cleanly.
        if (mem_ack) begin
          rdata_d   = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else if (cnt_expire) begin
          rdata_d   = {DATA_W{1'b0}};
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = RESP;
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and memory-interface registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {DATA_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      rdata_q     <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
    end
  end

  // Error and trap flags are only ever set for the single RESP cycle.
  assign bus_error  = err_q;
  assign misaligned = mis_q;

  assign result      = alu_result;
  assign reg_dst_out = reg_dst;
  assign read_data   = (state_q == RESP) ? rdata_q : {DATA_W{1'b0}};
  assign write_back_signal_out = (err_q || mis_q) ? WB_NONE : write_back_signal;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions, a behavioural
// memory with programmable ack delay, and monitors for requests and MEM/WB data.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mem_read, mem_write, mem_ack;
  logic [31:0] alu_result, write_data, mem_rdata;
  logic [4:0]  reg_dst;
  logic [1:0]  wb_in;

  logic        stall, bus_error, misaligned, mem_req, mem_we;
  logic [31:0] result, read_data, mem_addr, mem_wdata;
  logic [4:0]  reg_dst_out;
  logic [1:0]  wb_out;

  typedef struct {
    logic [31:0] result;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        berr;
    logic        mis;
    int          stalls;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    int          cycles;
  } req_t;

  resp_t exp_resp[$];
  req_t  exp_req[$];

  int          checks = 0;
  int          errors = 0;
  int          ack_delay = -1;
  logic        stray_ack = 1'b0;
  logic [31:0] rd_cfg = 32'h0;

  mem_access_unit #(.DATA_W(32), .MEM_TIMEOUT(16)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid                 (valid),
    .alu_result            (alu_result),
    .write_data            (write_data),
    .mem_read              (mem_read),
    .mem_write             (mem_write),
    .reg_dst               (reg_dst),
    .write_back_signal     (wb_in),
    .stall                 (stall),
    .result                (result),
    .read_data             (read_data),
    .reg_dst_out           (reg_dst_out),
    .write_back_signal_out (wb_out),
    .bus_error             (bus_error),
    .misaligned            (misaligned),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata),
    .mem_ack               (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_resp(input logic [31:0] res, input logic [31:0] rdata, input logic [4:0] rd,
                             input logic [1:0] wb, input logic berr, input logic mis, input int stalls);
    resp_t r;
    r.result = res; r.rdata = rdata; r.rd = rd; r.wb = wb;
    r.berr = berr; r.mis = mis; r.stalls = stalls;
    exp_resp.push_back(r);
  endtask

  task automatic expect_req(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                            input int cycles);
    req_t q;
    q.addr = addr; q.wdata = wdata; q.we = we; q.cycles = cycles;
    exp_req.push_back(q);
  endtask

  // Drive one instruction and hold it until the stall releases.
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rdst, input logic [1:0] wbs);
    int n;
    valid = 1'b1; mem_read = rd; mem_write = wr; alu_result = addr;
    write_data = wdata; reg_dst = rdst; wb_in = wbs;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 100);
    if (stall) begin
      errors++;
      $display("FAIL issue_timeout: stall still 1 after %0d cycles, required 0", n);
    end
    @(posedge clk);
    #1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Memory model: acks after ack_delay BUSY cycles (negative = never).
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_ack = (ack_delay >= 0) && (busy_cnt == ack_delay);
        busy_cnt++;
      end else begin
        mem_ack = stray_ack;
        busy_cnt = 0;
      end
      mem_rdata = rd_cfg;
    end
  end

  // Request monitor: checks issued address/data and how long mem_req stays up.
  initial begin
    int   req_run;
    req_t cur;
    req_run = 0;
    cur.cycles = 0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (req_run == 0) begin
          if (exp_req.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: mem_req=1 at addr 0x%0h, required no request", mem_addr);
            cur.cycles = -1;
          end else begin
            cur = exp_req.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_we", mem_we, cur.we);
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end
        req_run++;
      end else if (req_run != 0) begin
        if (cur.cycles >= 0) chk("req_cycles", req_run, cur.cycles);
        req_run = 0;
      end
    end
  end

  // Response monitor: compares what MEM/WB would capture, plus stall length.
  initial begin
    int    stall_run;
    resp_t e;
    stall_run = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_run = 0;
      end else if (valid) begin
        if (stall) begin
          stall_run++;
        end else begin
          if (exp_resp.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: result 0x%0h with no expected entry", result);
          end else begin
            e = exp_resp.pop_front();
            chk("result", result, e.result);
            chk("read_data", read_data, e.rdata);
            chk("reg_dst_out", reg_dst_out, e.rd);
            chk("wb_out", wb_out, e.wb);
            chk("bus_error", bus_error, e.berr);
            chk("misaligned", misaligned, e.mis);
            chk("stall_cycles", stall_run, e.stalls);
          end
          stall_run = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_result = 32'h0; write_data = 32'h0; reg_dst = 5'd0; wb_in = 2'b00;
    #2 rst = 1'b0;
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_bus_error", bus_error, 1'b0);
    chk("rst_misaligned", misaligned, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // ALU op with a stray ack on the bus: pure pass-through.
    stray_ack = 1'b1;
    expect_resp(32'h0000_0010, 32'h0, 5'd3, 2'b10, 1'b0, 1'b0, 0);
    issue(1'b0, 1'b0, 32'h0000_0010, 32'h0, 5'd3, 2'b10);
    stray_ack = 1'b0;

    // Bubble carrying a stale mem_read: no access.
    mem_read = 1'b1; alu_result = 32'h0000_0050;
    @(negedge clk);
    chk("bubble_stall", stall, 1'b0);
    @(posedge clk);
    #1 mem_read = 1'b0;

    // Load, ack in the third BUSY cycle.
    ack_delay = 2; rd_cfg = 32'hDEAD_BEEF;
    expect_req(32'h0000_0040, 32'h0, 1'b0, 3);
    expect_resp(32'h0000_0040, 32'hDEAD_BEEF, 5'd5, 2'b11, 1'b0, 1'b0, 4);
    issue(1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd5, 2'b11);

    // Store, immediate ack; memory data must not be captured.
    ack_delay = 0; rd_cfg = 32'hFFFF_FFFF;
    expect_req(32'h0000_0044, 32'h1234_5678, 1'b1, 1);
    expect_resp(32'h0000_0044, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 2);
    issue(1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 5'd0, 2'b00);

    // Load with no ack: times out after 16 BUSY cycles.
    ack_delay = -1; rd_cfg = 32'hA5A5_A5A5;
    expect_req(32'h0000_0080, 32'h0, 1'b0, 16);
    expect_resp(32'h0000_0080, 32'h0, 5'd7, 2'b00, 1'b1, 1'b0, 17);
    issue(1'b1, 1'b0, 32'h0000_0080, 32'h0, 5'd7, 2'b01);

    // Ack exactly in the 16th BUSY cycle wins over the timeout.
    ack_delay = 15; rd_cfg = 32'h0BAD_F00D;
    expect_req(32'h0000_0084, 32'h0, 1'b0, 16);
    expect_resp(32'h0000_0084, 32'h0BAD_F00D, 5'd8, 2'b01, 1'b0, 1'b0, 17);
    issue(1'b1, 1'b0, 32'h0000_0084, 32'h0, 5'd8, 2'b01);

    // mem_read and mem_write both set is a store.
    ack_delay = 1; rd_cfg = 32'h1111_1111;
    expect_req(32'h0000_0048, 32'hCAFE_BABE, 1'b1, 2);
    expect_resp(32'h0000_0048, 32'h0, 5'd9, 2'b10, 1'b0, 1'b0, 3);
    issue(1'b1, 1'b1, 32'h0000_0048, 32'hCAFE_BABE, 5'd9, 2'b10);

    // Unaligned load.
    ack_delay = 0; rd_cfg = 32'h55AA_55AA;
`ifdef MISALIGN_TRAP_EN
    expect_resp(32'h0000_0042, 32'h0, 5'd10, 2'b00, 1'b0, 1'b1, 1);
`else
    expect_req(32'h0000_0040, 32'h0, 1'b0, 1);
    expect_resp(32'h0000_0042, 32'h55AA_55AA, 5'd10, 2'b11, 1'b0, 1'b0, 2);
`endif
    issue(1'b1, 1'b0, 32'h0000_0042, 32'h0, 5'd10, 2'b11);

    // Reset during the second BUSY cycle of a load.
    ack_delay = -1;
    expect_req(32'h0000_0090, 32'h0, 1'b0, 1);
    valid = 1'b1; mem_read = 1'b1; alu_result = 32'h0000_0090; reg_dst = 5'd11; wb_in = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0; valid = 1'b0; mem_read = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 1'b0);
    chk("midrst_stall", stall, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_bus_error", bus_error, 1'b0);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    // Load after reset completes normally, followed back-to-back by an ALU op.
    ack_delay = 1; rd_cfg = 32'h600D_CAFE;
    expect_req(32'h0000_0100, 32'h0, 1'b0, 2);
    expect_resp(32'h0000_0100, 32'h600D_CAFE, 5'd12, 2'b11, 1'b0, 1'b0, 3);
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd12, 2'b11);
    expect_resp(32'h0000_0777, 32'h0, 5'd13, 2'b01, 1'b0, 1'b0, 0);
    issue(1'b0, 1'b0, 32'h0000_0777, 32'h0, 5'd13, 2'b01);

    repeat (3) @(posedge clk);
    chk("resp_queue_empty", exp_resp.size(), 0);
    chk("req_queue_empty", exp_req.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller in the 5-stage pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Issues load/store transactions to a variable-latency data memory over a req/ack handshake, stalls the pipeline until the access completes, and presents result, read data, destination register and write-back control for the MEM/WB register to capture.
- Includes a bus timeout counter that converts a hung access into a bus error.

Parameters:
- DATA_W, 32, data and address width.
- MEM_TIMEOUT, 16, number of BUSY cycles without mem_ack before the access is aborted; legal range 2..255.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low)
- valid  in  1  EX/MEM holds a valid instruction
- alu_result  in  32  ALU result, also the memory address
- write_data  in  32  store data
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- reg_dst  in  5  destination register
- write_back_signal  in  2  write-back control
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- result  out  32  to MEM/WB, equals alu_result
- read_data  out  32  load data to MEM/WB
- reg_dst_out  out  5  to MEM/WB
- write_back_signal_out  out  2  to MEM/WB
- bus_error  out  1  one-cycle pulse, access timed out
- misaligned  out  1  one-cycle pulse, misaligned access (see Optional Feature)
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address
- mem_wdata  out  32  store data
- mem_rdata  in  32  memory read data
- mem_ack  in  1  memory completion, single-cycle

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset values:
  - state = IDLE
  - mem_req, mem_we = 0; mem_addr, mem_wdata = 0
  - captured read data = 0; timeout counter = 0
  - bus_error, misaligned = 0
- An access is `valid && (mem_read || mem_write)`. If mem_read and mem_write are both set, the access is a store.
- IDLE, no access:
  - zero-latency pass-through: result = alu_result, reg_dst_out = reg_dst, write_back_signal_out = write_back_signal
  - read_data = 0, stall = 0
- IDLE, access:
  - stall = 1 (combinational)
  - at the clock edge: register mem_addr = {alu_result[31:2], 2'b00}, mem_wdata = write_data, mem_we = mem_write; set mem_req = 1; clear counter; go to BUSY
- BUSY:
  - stall = 1; mem_req held at 1; counter increments every cycle
  - mem_ack = 1: capture mem_rdata (loads only; stores capture 0), drop mem_req, go to RESP
  - counter = MEM_TIMEOUT-1 with no ack: drop mem_req, captured data = 0, set error flag, go to RESP
  - ack arriving in the same cycle as expiry: ack wins, no error
- RESP:
  - stall = 0; read_data = captured data; pass-through outputs as in IDLE (inputs are still held by the stall)
  - bus_error = 1 for this cycle only if the access timed out; write_back_signal_out is then forced to 2'b00
  - next state is IDLE unconditionally, so back-to-back accesses get a fresh IDLE decision
- mem_ack in IDLE or RESP is ignored.
- Latency: minimum 2 stall cycles (IDLE, BUSY with immediate ack); result valid in RESP, captured by MEM/WB at the following edge.
- Reset mid-access: mem_req drops immediately and asynchronously, FSM returns to IDLE, no bus_error pulse.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: an access with alu_result[1:0] != 0 issues no memory request. The FSM goes IDLE -> RESP in one stall cycle; RESP drives misaligned = 1, read_data = 0, write_back_signal_out = 2'b00.
- Undefined: low address bits are ignored (word-aligned access) and misaligned is tied 0.

Decomposition:
- Shared package mem_stage_pkg:
  - FSM state encoding: IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2
  - DATA_W, REG_ADDR_W = 5, WB_SIG_W = 2
  - WB_NONE = 2'b00
- One sub-module, mem_timeout_counter: clear, enable and expire outputs, width $clog2(MEM_TIMEOUT). The FSM stays in mem_access_unit.

Test Plan:
- ALU instruction (valid=1, mem_read=0, mem_write=0, alu_result=0x0000_0010) -> stall=0, result=0x10, read_data=0, no mem_req.
- Load at 0x0000_0040, mem_ack after 3 BUSY cycles with mem_rdata=0xDEAD_BEEF -> stall high for 4 cycles, mem_addr=0x40, mem_we=0; RESP read_data=0xDEAD_BEEF, stall=0.
- Store at 0x0000_0044, data 0x1234_5678, immediate ack -> mem_we=1, mem_wdata=0x1234_5678, exactly 2 stall cycles, read_data=0.
- Load with no ack, MEM_TIMEOUT=16 -> mem_req high for 16 cycles then drops; RESP has bus_error=1, write_back_signal_out=00, read_data=0; ack exactly on the 16th cycle -> no error.
- rst asserted in the 2nd BUSY cycle -> mem_req=0 immediately, state IDLE, no bus_error; a following load completes normally.
- With MISALIGN_TRAP_EN: load at 0x0000_0042 -> no mem_req, 1 stall cycle, misaligned=1, write_back_signal_out=00; without the macro -> mem_addr=0x40, normal completion.
